// File: rtl/fp_alu_sched_pkg.sv
// Shared definitions for the FP ALU scheduler: opcodes, FSM state
// encoding and the default operand settle time.
package fp_alu_sched_pkg;

  localparam int SETTLE_CYC_DEF = 2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  // Any opcode with bit 2 set is a compare; this is the canonical value.
  localparam logic [2:0] OP_CMP = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_cmp(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/fp_alu_sched_alu.sv
// Combinational single-precision FP ALU shared by the scheduler.
// Denormal inputs are flushed to zero, results truncate toward zero,
// overflow saturates to infinity. Invalid divides (x/0, inf/nan operand)
// are gated to 0.
// Ports:
//   o        opcode (only distinguishes add from sub here)
//   a, b     IEEE-754 single operands
//   add_sub  a+b or a-b
//   mul      a*b
//   div      a/b (0 when invalid)
//   lt/gt/eq ordered compare of a against b (all 0 if either is NaN)
module fp_alu_sched_alu
  import fp_alu_sched_pkg::*;
(
  input  logic [2:0]  o,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] add_sub,
  output logic [31:0] mul,
  output logic [31:0] div,
  output logic        lt,
  output logic        gt,
  output logic        eq
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        sa, sb, za, zb, spa, spb, nan_any;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;

  assign sa      = a[31];
  assign sb      = b[31];
  assign ea      = a[30:23];
  assign eb      = b[30:23];
  assign za      = (ea == 8'd0);
  assign zb      = (eb == 8'd0);
  assign spa     = (ea == 8'hFF);
  assign spb     = (eb == 8'hFF);
  assign ma      = za ? 24'd0 : {1'b1, a[22:0]};
  assign mb      = zb ? 24'd0 : {1'b1, b[22:0]};
  assign nan_any = (spa && a[22:0] != 23'd0) || (spb && b[22:0] != 23'd0);

  // Biased exponent out of range flushes to signed zero or saturates to inf.
  function automatic logic [31:0] pack(input logic s, input logic signed [10:0] e,
                                       input logic [22:0] f);
    logic [31:0] r;
    r = {s, e[7:0], f};
    if (e <= 11'sd0)        r = {s, 31'd0};
    else if (e >= 11'sd255) r = {s, 8'hFF, 23'd0};
    return r;
  endfunction

  // Add/sub: x is the larger magnitude, y is aligned to it.
  logic               sb_eff, swap, sx;
  logic [7:0]         ex, dexp;
  logic [27:0]        mx, my, sum, norm;
  logic [4:0]         lead;
  logic signed [10:0] e_add;

  always_comb begin
    sb_eff = sb ^ (o == OP_SUB);
    swap   = {eb, mb} > {ea, ma};
    sx     = swap ? sb_eff : sa;
    ex     = swap ? eb : ea;
    dexp   = swap ? eb - ea : ea - eb;
    mx     = {1'b0, (swap ? mb : ma), 3'b000};
    my     = {1'b0, (swap ? ma : mb), 3'b000} >> dexp;
    sum    = (sa != sb_eff) ? mx - my : mx + my;
    lead   = 5'd0;
    for (int i = 0; i < 28; i++) if (sum[i]) lead = 5'(i);
    norm   = sum << (5'd27 - lead);
    e_add  = 11'(ex) + 11'(lead) - 11'sd26;
    if (spa || spb)        add_sub = QNAN;
    else if (sum == 28'd0) add_sub = 32'd0;
    else                   add_sub = pack(sx, e_add, norm[26:4]);
  end

  logic [47:0]        prod;
  logic signed [10:0] e_mul;

  always_comb begin
    prod  = 48'(ma) * 48'(mb);
    e_mul = 11'(ea) + 11'(eb) - 11'sd127 + 11'(prod[47]);
    if (spa || spb)    mul = QNAN;
    else if (za || zb) mul = {sa ^ sb, 31'd0};
    else               mul = pack(sa ^ sb, e_mul, prod[47] ? prod[46:24] : prod[45:23]);
  end

  // Quotient lands in [2^24, 2^26); bit 25 tells whether ma >= mb.
  logic [48:0]        quo;
  logic signed [10:0] e_div;

  always_comb begin
    quo   = {ma, 25'd0} / 49'(zb ? 24'd1 : mb);
    e_div = 11'(ea) - 11'(eb) + 11'sd126 + 11'(quo[25]);
    if (zb || spa || spb) div = 32'd0;
    else if (za)          div = {sa ^ sb, 31'd0};
    else                  div = pack(sa ^ sb, e_div, quo[25] ? quo[24:2] : quo[23:1]);
  end

  // Sign-magnitude to monotonic key: negatives inverted, positives get MSB set.
  logic [31:0] ka, kb;

  always_comb begin
    ka = sa ? ~a : (a | 32'h8000_0000);
    kb = sb ? ~b : (b | 32'h8000_0000);
    eq = !nan_any && ((a == b) || (za && zb));
    lt = !nan_any && !eq && (ka < kb);
    gt = !nan_any && !eq && (ka > kb);
  end

  logic unused_bits;
  assign unused_bits = ^{norm[27], norm[3:0], prod[22:0], quo[48:26], quo[0]};

endmodule

// File: rtl/fp_alu_sched.sv
// Two-requester scheduler in front of the shared FP ALU. One operation in
// flight: arbitrate, hold operands on the ALU for SETTLE_CYC cycles, then
// present the captured result until the consumer takes it.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   reqN_valid/ready/op/a/b          requester N handshake and operands
//   resp_valid/ready/id/data         response handshake, owner and result
//   resp_lt/gt/eq                    compare flags (compare ops only)
//   busy                             high whenever not IDLE
//
// state   | meaning
// IDLE    | arbitrate, accept one request
// EXEC    | operands held on ALU, cnt counting down to capture
// RESP    | result held until resp_ready
module fp_alu_sched
  import fp_alu_sched_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data,
  output logic        resp_lt,
  output logic        resp_gt,
  output logic        resp_eq,
  output logic        busy
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        last_grant, grant_id, accept, capture, id_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, res_sel;
  logic [31:0] alu_add_sub, alu_mul, alu_div;
  logic        alu_lt, alu_gt, alu_eq;

  // Lone requester wins; on a tie the one not granted last time wins.
  assign grant_id = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        // rst_n gating keeps ready low while reset is asserted.
        req0_ready = rst_n && req0_valid && !grant_id;
        req1_ready = rst_n && req1_valid && grant_id;
        if (req0_ready || req1_ready) begin
          accept   = 1'b1;
          state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt == 4'd0) begin
          capture  = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    res_sel = 32'd0;
    case (op_q)
      OP_ADD, OP_SUB: res_sel = alu_add_sub;
      OP_MUL:         res_sel = alu_mul;
      OP_DIV:         res_sel = alu_div;
      default:        res_sel = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      op_q       <= 3'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      id_q       <= 1'b0;
      resp_data  <= 32'd0;
      resp_id    <= 1'b0;
      resp_lt    <= 1'b0;
      resp_gt    <= 1'b0;
      resp_eq    <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= grant_id ? req1_op : req0_op;
        a_q        <= grant_id ? req1_a : req0_a;
        b_q        <= grant_id ? req1_b : req0_b;
        id_q       <= grant_id;
        last_grant <= grant_id;
        cnt        <= CNT_LOAD;
      end else if (state == ST_EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        resp_data <= res_sel;
        resp_id   <= id_q;
        resp_lt   <= is_cmp(op_q) && alu_lt;
        resp_gt   <= is_cmp(op_q) && alu_gt;
        resp_eq   <= is_cmp(op_q) && alu_eq;
      end
    end
  end

  fp_alu_sched_alu u_alu (
    .o       (op_q),
    .a       (a_q),
    .b       (b_q),
    .add_sub (alu_add_sub),
    .mul     (alu_mul),
    .div     (alu_div),
    .lt      (alu_lt),
    .gt      (alu_gt),
    .eq      (alu_eq)
  );

endmodule

// File: tb/tb_fp_alu_sched.sv
// Self-checking bench for fp_alu_sched: directed vector table, hand-written
// arbitration/stall/reset sequences, and randomized traffic checked against
// a real-arithmetic reference model.
module tb_fp_alu_sched;
  import fp_alu_sched_pkg::*;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic        resp_valid, resp_id, resp_lt, resp_gt, resp_eq, busy;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;

  always #5 clk = ~clk;

  fp_alu_sched #(.SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_lt(resp_lt), .resp_gt(resp_gt),
    .resp_eq(resp_eq), .busy(busy)
  );

  typedef struct {
    bit          id;
    logic [2:0]  op;
    logic [31:0] a, b, data;
    logic        lt, gt, eq;
    string       name;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  bit model_last = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (req0_ready && req1_ready) begin
        n_bad++;
        $display("FAIL ready_onehot: got both ready, expected at most one");
      end
    end
  end

  function automatic vec_t mk(input bit id, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] d,
                              input logic lt, input logic gt, input logic eq,
                              input string name);
    vec_t v;
    v.id = id; v.op = op; v.a = a; v.b = b; v.data = d;
    v.lt = lt; v.gt = gt; v.eq = eq; v.name = name;
    return v;
  endfunction

  // Real value to single-precision bits (exact for the small values used here).
  function automatic logic [31:0] r2f(input real r);
    logic s; int e; real m;
    if (r == 0.0) return 32'd0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  function automatic int rand_int();
    int v;
    v = int'($urandom_range(1, 64));
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  task automatic gen_rand(input bit id, output vec_t v);
    int ia, ib, k;
    real ra, rb, rr;
    v.id = id;
    v.op = 3'($urandom_range(0, 7));
    v.name = "rand";
    ia = rand_int();
    ib = rand_int();
    if (v.op == OP_DIV) begin
      k  = int'($urandom_range(0, 4));
      ib = (k == 4) ? 0 : (1 << k);
      if ($urandom_range(0, 1) == 1) ib = -ib;
    end
    if (v.op[2] && $urandom_range(0, 3) == 0) ib = ia;
    ra = ia; rb = ib; rr = 0.0;
    v.a = r2f(ra); v.b = r2f(rb);
    v.lt = 1'b0; v.gt = 1'b0; v.eq = 1'b0;
    if (v.op[2]) begin
      v.lt = (ra < rb); v.gt = (ra > rb); v.eq = (ra == rb);
    end else if (v.op == OP_ADD) rr = ra + rb;
    else if (v.op == OP_SUB) rr = ra - rb;
    else if (v.op == OP_MUL) rr = ra * rb;
    else if (ib != 0) rr = ra / rb;
    v.data = r2f(rr);
  endtask

  task automatic wait_ready(input bit id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = id ? req1_ready : req0_ready;
      if (!ok) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release_resp(input string name);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    #1;
    chk({name, " resp_drop"}, resp_valid, 1'b0);
    chk({name, " busy_idle"}, busy, 1'b0);
  endtask

  task automatic check_resp(input vec_t v, input int lat);
    chk({v.name, " latency"}, lat, S);
    chk({v.name, " data"}, resp_data, v.data);
    chk({v.name, " id"}, resp_id, v.id);
    chk({v.name, " lt"}, resp_lt, v.lt);
    chk({v.name, " gt"}, resp_gt, v.gt);
    chk({v.name, " eq"}, resp_eq, v.eq);
  endtask

  task automatic transact(input vec_t v, input bit tie, input int hold);
    bit ok;
    int lat;
    if (v.id) begin req1_valid = 1; req1_op = v.op; req1_a = v.a; req1_b = v.b; end
    else      begin req0_valid = 1; req0_op = v.op; req0_a = v.a; req0_b = v.b; end
    if (tie) begin
      if (v.id) begin req0_valid = 1; req0_op = 3'($urandom); req0_a = $urandom; req0_b = $urandom; end
      else      begin req1_valid = 1; req1_op = 3'($urandom); req1_a = $urandom; req1_b = $urandom; end
    end
    wait_ready(v.id, ok);
    chk({v.name, " grant"}, ok, 1'b1);
    chk({v.name, " other_ready"}, v.id ? req0_ready : req1_ready, 1'b0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    req0_op = 3'($urandom); req0_a = $urandom; req0_b = $urandom;
    req1_op = 3'($urandom); req1_a = $urandom; req1_b = $urandom;
    if (!ok) return;
    wait_resp(lat);
    check_resp(v, lat);
    chk({v.name, " busy"}, busy, 1'b1);
    repeat (hold) begin @(posedge clk); #1; end
    if (hold > 0) chk({v.name, " held_data"}, resp_data, v.data);
    release_resp(v.name);
    model_last = v.id;
  endtask

  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int lat;
    vec_t v;

    tbl[0] = mk(0, OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 0, "add_1_2");
    tbl[1] = mk(1, OP_CMP, 32'h3F800000, 32'h40000000, 32'h00000000, 1, 0, 0, "cmp_lt");
    tbl[2] = mk(1, 3'b111, 32'h40000000, 32'h40000000, 32'h00000000, 0, 0, 1, "cmp_eq");
    tbl[3] = mk(0, OP_SUB, 32'h40400000, 32'h3F800000, 32'h40000000, 0, 0, 0, "sub_3_1");
    tbl[4] = mk(1, OP_MUL, 32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0, "mul_2_3");
    tbl[5] = mk(0, OP_DIV, 32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 0, "div_6_2");
    tbl[6] = mk(0, OP_DIV, 32'h3F800000, 32'h00000000, 32'h00000000, 0, 0, 0, "div_by_0");
    tbl[7] = mk(1, 3'b101, 32'h40400000, 32'hBF800000, 32'h00000000, 0, 1, 0, "cmp_gt_neg");
    tbl[8] = mk(0, OP_ADD, 32'h3F800000, 32'hBF800000, 32'h00000000, 0, 0, 0, "add_cancel");

    // Reset state, with a requester already valid.
    req0_valid = 1;
    #12;
    chk("rst req0_ready", req0_ready, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst resp_valid", resp_valid, 1'b0);
    chk("rst resp_data", resp_data, 32'd0);
    chk("rst resp_id", resp_id, 1'b0);
    chk("rst flags", {resp_lt, resp_gt, resp_eq}, 3'b000);
    req0_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // Tie right after reset: req0 first, then req1 after one IDLE bubble.
    req0_valid = 1; req0_op = OP_MUL; req0_a = 32'h40000000; req0_b = 32'h40400000;
    req1_valid = 1; req1_op = OP_DIV; req1_a = 32'h40C00000; req1_b = 32'h40000000;
    #1;
    chk("tie req0_ready", req0_ready, 1'b1);
    chk("tie req1_ready", req1_ready, 1'b0);
    @(posedge clk); #1;
    req0_valid = 0; req0_a = 32'hDEADBEEF;
    #1;
    chk("tie req1_ready exec", req1_ready, 1'b0);
    wait_resp(lat);
    check_resp(mk(0, OP_MUL, 0, 0, 32'h40C00000, 0, 0, 0, "tie_first"), lat);
    chk("tie req1_ready resp", req1_ready, 1'b0);
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    #1;
    chk("tie req1_ready bubble", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 0; req1_b = 32'h12345678;
    wait_resp(lat);
    check_resp(mk(1, OP_DIV, 0, 0, 32'h40400000, 0, 0, 0, "tie_second"), lat);
    release_resp("tie_second");
    model_last = 1;

    for (int i = 0; i < 9; i++) transact(tbl[i], 1'b0, i % 3);

    // Consumer stall: response frozen, pending requester not accepted.
    v = mk(0, OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 0, "stall");
    req0_valid = 1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
    wait_ready(0, ok);
    chk("stall grant", ok, 1'b1);
    @(posedge clk); #1;
    req0_op = OP_SUB; req0_a = 32'h40400000; req0_b = 32'h3F800000;
    wait_resp(lat);
    check_resp(v, lat);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall resp_valid", resp_valid, 1'b1);
      chk("stall resp_data", resp_data, 32'h40400000);
      chk("stall req0_ready", req0_ready, 1'b0);
      @(posedge clk); #1;
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    #1;
    chk("stall bubble resp_valid", resp_valid, 1'b0);
    chk("stall bubble req0_ready", req0_ready, 1'b1);
    @(posedge clk); #1;
    chk("stall reaccept busy", busy, 1'b1);
    req0_valid = 0;
    wait_resp(lat);
    check_resp(mk(0, OP_SUB, 0, 0, 32'h40000000, 0, 0, 0, "stall_next"), lat);
    release_resp("stall_next");
    model_last = 0;

    // Randomized traffic against the real-arithmetic model.
    for (int t = 0; t < 40; t++) begin
      bit tie, id;
      int hold, gap;
      tie  = ($urandom_range(0, 2) == 0);
      id   = tie ? !model_last : 1'($urandom_range(0, 1));
      hold = int'($urandom_range(0, 3));
      gap  = int'($urandom_range(0, 2));
      gen_rand(id, v);
      repeat (gap) begin @(posedge clk); #1; end
      transact(v, tie, hold);
    end

    // Reset in the middle of EXEC discards the in-flight op.
    transact(mk(1, OP_MUL, 32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0, "pre_rst"), 1'b0, 0);
    req0_valid = 1; req0_op = OP_ADD; req0_a = 32'h3F800000; req0_b = 32'h40000000;
    wait_ready(0, ok);
    chk("mid_rst grant", ok, 1'b1);
    @(posedge clk); #1;
    #1;
    rst_n = 0;
    #1;
    chk("mid_rst busy", busy, 1'b0);
    chk("mid_rst resp_valid", resp_valid, 1'b0);
    chk("mid_rst resp_data", resp_data, 32'd0);
    chk("mid_rst resp_id", resp_id, 1'b0);
    chk("mid_rst req0_ready", req0_ready, 1'b0);
    req0_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_last = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("post_rst no_resp", resp_valid, 1'b0);
    end
    transact(mk(0, OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 0, "post_rst_tie"),
             1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_alu_sched.md
FP_ALU_SCHED -- requirements
Module: fp_alu_sched

Interface
REQ-001 Parameter SETTLE_CYC, default 2, number of EXEC cycles operands are held on the ALU before capture (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester N's operation is accepted this cycle.
REQ-006 req0_op / req1_op  input  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 1xx compare.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  32  IEEE-754 single-precision operands.
REQ-008 resp_valid  output  1  response holds a completed result.
REQ-009 resp_ready  input  1  consumer accepts the response.
REQ-010 resp_id  output  1  requester index (0/1) that owns the response.
REQ-011 resp_data  output  32  result word.
REQ-012 resp_lt / resp_gt / resp_eq  output  1  compare flags a<b, a>b, a==b.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, EXEC, RESP; reset state IDLE.
REQ-015 IDLE: grant is combinational; a single valid requester is granted; if both are valid, the requester not in last_grant is granted.
REQ-016 reqN_ready is high only in IDLE and only for the granted N; the ready signals are never both high.
REQ-017 Accept (valid & ready at an edge): register op, a, b and id; load cnt = SETTLE_CYC-1; set last_grant = id; go to EXEC.
REQ-018 EXEC: registered op/a/b drive the ALU continuously and stay stable; cnt decrements each cycle; when cnt==0, the next edge captures ALU outputs into the response registers and moves to RESP.
REQ-019 Latency: if accept is at edge k, resp_valid rises after edge k+SETTLE_CYC.
REQ-020 Result selection: op 000/001 -> ALU add_sub output; 010 -> mul; 011 -> divide; 1xx -> resp_data = 0.
REQ-021 Compare flags are taken from the ALU only for op 1xx; for all other ops they are 0.
REQ-022 RESP: resp_valid = 1; resp_data, resp_id and flags are held stable until resp_valid & resp_ready at an edge, which moves to IDLE.
REQ-023 resp_ready low holds RESP indefinitely; no new request is accepted (at most one operation in flight).
REQ-024 Minimum spacing between accepts is SETTLE_CYC+2 cycles; one IDLE bubble follows each response.
REQ-025 A requester may drop valid before accept without side effects; operands sampled only at the accept edge are used.
REQ-026 ALU division-invalid cases yield resp_data = 0 (the ALU's gated output), passed through unchanged.

Reset
REQ-027 rst_n low asynchronously forces state IDLE, cnt 0, last_grant 1 (req0 wins first tie), operand and response registers 0, and resp_valid, busy, req ready, flags and resp_id all 0.
REQ-028 Reset during EXEC or RESP discards the in-flight operation; no response is ever produced for it.

Structure
REQ-029 A shared package holds opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP prefix 1), the FSM state encoding and the SETTLE_CYC default.
REQ-030 Exactly one sub-module: the existing ALU, instantiated once, with its o input driven by the registered op.
REQ-031 The block contains no arithmetic beyond the cnt decrement and the arbitration logic.

Verification
REQ-032 req0 add a=0x3F800000 b=0x40000000 at edge 0 -> resp_valid after edge 2, resp_data 0x40400000, resp_id 0, flags 000.
REQ-033 Both valid in the same cycle after reset (req0 mul 0x40000000*0x40400000, req1 div 0x40C00000/0x40000000) -> req0 served first with data 0x40C00000, then req1 with data 0x40400000, resp_id 1.
REQ-034 req1 compare a=0x3F800000 b=0x40000000 -> resp_lt=1, resp_gt=0, resp_eq=0, resp_data 0; equal operands -> resp_eq=1.
REQ-035 resp_ready held low 10 cycles in RESP -> resp_valid and data stable, req ready stays 0 with req0_valid high; accept follows one cycle after resp_ready rises.
REQ-036 rst_n pulsed low mid-EXEC -> outputs 0 immediately, no resp_valid afterwards, next request is served normally with req0 winning a tie.
